// File: rtl/citadel_pkg.sv
// Shared definitions for the citadel key presenter and the Sentinel lock it talks to.
// Holds the state codes, the default key and the status-line polarity.
package citadel_pkg;

    localparam logic [7:0] KEY_VALUE_DEFAULT = 8'hB6;

    // Lock status line: a high level on the glow segment means the lock accepts the key.
    localparam logic STATUS_GLOW_ON = 1'b1;

    // IDLE and FAULT sit at the all-zero and all-one corners. Every active code has weight 4,
    // so it is 4 flips from both corners. Any two active codes share at most 2 set bits,
    // which keeps them at least 4 flips apart. A single upset therefore never turns one
    // legal state into another; it lands on an illegal code and is trapped into FAULT.
    typedef enum logic [7:0] {
        ST_IDLE    = 8'h00,
        ST_PRESENT = 8'h0F,
        ST_HOLD    = 8'h33,
        ST_GAP     = 8'h55,
        ST_GRANTED = 8'h96,
        ST_DENIED  = 8'hA5,
        ST_FAULT   = 8'hFF
    } state_t;

    function automatic logic state_is_legal(input logic [7:0] s);
        case (s)
            ST_IDLE, ST_PRESENT, ST_HOLD, ST_GAP,
            ST_GRANTED, ST_DENIED, ST_FAULT: return 1'b1;
            default:                         return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/citadel_sync2.sv
// Two-flop synchronizer for the asynchronous lock status line.
// It always runs; it is never gated by the power-state enable.
module citadel_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/citadel_key_presenter.sv
// Initiator side of the Sentinel lock: presents the key, waits for a stable glow,
// retries after timeouts or lost grants, and traps corrupted state codes into FAULT.
module citadel_key_presenter
    import citadel_pkg::*;
#(
    parameter logic [7:0] KEY_VALUE   = KEY_VALUE_DEFAULT,
    parameter int         ACK_TIMEOUT = 16,
    parameter int         HOLD_CYCLES = 4,
    parameter int         GAP_CYCLES  = 4,
    parameter int         MAX_RETRIES = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       start,
    input  logic       release_req,
    input  logic       abort,
    input  logic       lock_status,
    output logic [7:0] key_out,
    output logic       busy,
    output logic       granted,
    output logic       denied,
    output logic       fault,
    output logic [1:0] retry_count
);
    localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int GW = (GAP_CYCLES > 1)  ? $clog2(GAP_CYCLES)  : 1;

    (* keep = "true" *) logic [7:0] state_reg;
    logic [TW-1:0] timer;
    logic [HW-1:0] hold_cnt;
    logic [GW-1:0] gap_cnt;
    logic          sync_status;

    citadel_sync2 u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (lock_status),
        .q     (sync_status)
    );

    logic          glow;
    logic          timer_done;
    logic          hold_done;
    logic          gap_done;
    logic          retries_spent;
    logic [TW-1:0] timer_step;
    logic [7:0]    fail_state;

    assign glow          = (sync_status == STATUS_GLOW_ON);
    assign timer_done    = (timer == TW'(ACK_TIMEOUT - 1));
    assign hold_done     = (hold_cnt == HW'(HOLD_CYCLES - 1));
    assign gap_done      = (gap_cnt == GW'(GAP_CYCLES - 1));
    assign retries_spent = (retry_count == 2'(MAX_RETRIES));
    // Timer saturates so that entering HOLD on the last allowed cycle times out right after.
    assign timer_step    = timer_done ? timer : timer + TW'(1);
    assign fail_state    = retries_spent ? ST_DENIED : ST_GAP;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            timer       <= '0;
            hold_cnt    <= '0;
            gap_cnt     <= '0;
            retry_count <= '0;
        end else if (ena) begin
            if (!state_is_legal(state_reg)) begin
                state_reg <= ST_FAULT;
            end else if (state_reg == ST_FAULT) begin
                state_reg <= ST_FAULT;
            end else if (abort && state_reg != ST_IDLE) begin
                state_reg   <= ST_IDLE;
                retry_count <= '0;
            end else if (release_req && state_reg == ST_GRANTED) begin
                state_reg   <= ST_IDLE;
                retry_count <= '0;
            end else if (start && (state_reg == ST_IDLE || state_reg == ST_DENIED)) begin
                state_reg   <= ST_PRESENT;
                timer       <= '0;
                retry_count <= '0;
            end else begin
                case (state_reg)
                    ST_PRESENT: begin
                        if (glow) begin
                            state_reg <= ST_HOLD;
                            hold_cnt  <= '0;
                            timer     <= timer_step;
                        end else if (timer_done) begin
                            state_reg <= fail_state;
                            if (!retries_spent) begin
                                retry_count <= retry_count + 2'd1;
                                gap_cnt     <= '0;
                            end
                        end else begin
                            timer <= timer_step;
                        end
                    end
                    ST_HOLD: begin
                        if (glow && hold_done) begin
                            state_reg <= ST_GRANTED;
                        end else if (timer_done) begin
                            state_reg <= fail_state;
                            if (!retries_spent) begin
                                retry_count <= retry_count + 2'd1;
                                gap_cnt     <= '0;
                            end
                        end else if (!glow) begin
                            state_reg <= ST_PRESENT;
                            timer     <= timer_step;
                        end else begin
                            hold_cnt <= hold_cnt + HW'(1);
                            timer    <= timer_step;
                        end
                    end
                    ST_GAP: begin
                        if (gap_done) begin
                            state_reg <= ST_PRESENT;
                            timer     <= '0;
                        end else begin
                            gap_cnt <= gap_cnt + GW'(1);
                        end
                    end
                    ST_GRANTED: begin
                        // Losing the glow after a grant counts as a failed attempt.
                        if (!glow) begin
                            state_reg <= fail_state;
                            if (!retries_spent) begin
                                retry_count <= retry_count + 2'd1;
                                gap_cnt     <= '0;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign busy    = (state_reg == ST_PRESENT) || (state_reg == ST_HOLD) || (state_reg == ST_GAP);
    assign granted = (state_reg == ST_GRANTED);
    assign denied  = (state_reg == ST_DENIED);
    assign fault   = (state_reg == ST_FAULT);
    assign key_out = (ena && ((state_reg == ST_PRESENT) || (state_reg == ST_HOLD) ||
                              (state_reg == ST_GRANTED))) ? KEY_VALUE : 8'h00;

endmodule

// File: tb/tb_citadel_key_presenter.sv
// Bench for citadel_key_presenter: directed scenarios with literal expectations plus a
// randomized run, all checked every cycle against a behavioural model of the unlock protocol.
module tb_citadel_key_presenter;
    import citadel_pkg::*;

    localparam logic [7:0] KEY   = 8'hB6;
    localparam int         ACK   = 16;
    localparam int         HOLDC = 4;
    localparam int         GAPC  = 4;
    localparam int         MAXR  = 3;

    // ---------------- clock / reset / DUT ----------------
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b0;
    logic       start = 1'b0;
    logic       release_req = 1'b0;
    logic       abort = 1'b0;
    logic       lock_status = 1'b0;
    logic [7:0] key_out;
    logic       busy;
    logic       granted;
    logic       denied;
    logic       fault;
    logic [1:0] retry_count;

    always #5 clk = ~clk;

    citadel_key_presenter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .start       (start),
        .release_req (release_req),
        .abort       (abort),
        .lock_status (lock_status),
        .key_out     (key_out),
        .busy        (busy),
        .granted     (granted),
        .denied      (denied),
        .fault       (fault),
        .retry_count (retry_count)
    );

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    typedef enum int {M_IDLE, M_PRESENT, M_HOLD, M_GAP, M_GRANTED, M_DENIED} m_phase_t;
    m_phase_t m_ph      = M_IDLE;
    int       m_elapsed = 0;   // enabled cycles spent acknowledging in this attempt
    int       m_run     = 0;   // consecutive glowing HOLD cycles already counted
    int       m_gap     = 0;
    int       m_fails   = 0;
    bit       m_s1      = 1'b0;
    bit       m_s2      = 1'b0;

    task automatic m_fail();
        if (m_fails >= MAXR) m_ph = M_DENIED;
        else begin
            m_fails++;
            m_ph  = M_GAP;
            m_gap = 0;
        end
    endtask

    task automatic model_step();
        bit s;
        bit timed_out;
        s    = m_s2;
        m_s2 = m_s1;
        m_s1 = lock_status;
        if (!ena) return;
        timed_out = (m_elapsed >= ACK - 1);
        if (abort && m_ph != M_IDLE) begin
            m_ph = M_IDLE; m_fails = 0;
        end else if (release_req && m_ph == M_GRANTED) begin
            m_ph = M_IDLE; m_fails = 0;
        end else if (start && (m_ph == M_IDLE || m_ph == M_DENIED)) begin
            m_ph = M_PRESENT; m_elapsed = 0; m_fails = 0;
        end else begin
            case (m_ph)
                M_PRESENT:
                    if (s) begin m_ph = M_HOLD; m_run = 0; m_elapsed++; end
                    else if (timed_out) m_fail();
                    else m_elapsed++;
                M_HOLD:
                    if (s && m_run == HOLDC - 1) m_ph = M_GRANTED;
                    else if (timed_out) m_fail();
                    else if (!s) begin m_ph = M_PRESENT; m_elapsed++; end
                    else begin m_run++; m_elapsed++; end
                M_GAP:
                    if (m_gap == GAPC - 1) begin m_ph = M_PRESENT; m_elapsed = 0; end
                    else m_gap++;
                M_GRANTED:
                    if (!s) m_fail();
                default: ;
            endcase
        end
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_ph = M_IDLE; m_elapsed = 0; m_run = 0; m_gap = 0; m_fails = 0;
            m_s1 = 1'b0; m_s2 = 1'b0;
        end else begin
            model_step();
        end
    end

    // ---------------- per-cycle scoreboard ----------------
    initial forever begin
        logic [7:0] exp_key;
        @(negedge clk);
        if (chk_en) begin
            exp_key = (ena && (m_ph inside {M_PRESENT, M_HOLD, M_GRANTED})) ? KEY : 8'h00;
            check("cyc_key_out", 32'(key_out), 32'(exp_key));
            check("cyc_busy", 32'(busy), 32'(m_ph inside {M_PRESENT, M_HOLD, M_GAP}));
            check("cyc_granted", 32'(granted), 32'(m_ph == M_GRANTED));
            check("cyc_denied", 32'(denied), 32'(m_ph == M_DENIED));
            check("cyc_fault", 32'(fault), 32'd0);
            check("cyc_retry", 32'(retry_count), 32'(m_fails));
        end
    end

    // ---------------- driver ----------------
    int lock_mode   = 0;     // 0 silent, 1 follows the key one cycle late, 2 random glow
    bit key_prev_ok = 1'b0;
    bit glitch      = 1'b0;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        #1;
        if (lock_mode == 1)      lock_status = glitch ? 1'b0 : key_prev_ok;
        else if (lock_mode == 2) lock_status = ($urandom_range(0, 3) != 0) ? lock_status : ~lock_status;
        else                     lock_status = 1'b0;
        glitch      = 1'b0;
        key_prev_ok = (key_out == KEY);
    endtask

    task automatic pulse_start();
        start = 1'b1; step(); start = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; release_req = 1'b0; ena = 1'b1;
        lock_mode = 0; glitch = 1'b0; lock_status = 1'b0; key_prev_ok = 1'b0;
        step(); step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        do_reset();
        chk_en = 1'b1;
        check("rst_key", 32'(key_out), 32'h00);
        check("rst_flags", 32'({busy, granted, denied, fault}), 32'h0);
        check("rst_retry", 32'(retry_count), 32'd0);

        // Grant path: lock glows the cycle after seeing the key.
        lock_mode = 1;
        pulse_start();
        check("grant_key_e0", 32'(key_out), 32'(KEY));
        repeat (4) step();
        check("grant_hold_e4", 32'(dut.state_reg), 32'(ST_HOLD));
        check("grant_model_hold_e4", 32'(m_ph), 32'(M_HOLD));
        repeat (3) step();
        check("grant_not_yet_e7", 32'(granted), 32'd0);
        step();
        check("grant_e8", 32'(granted), 32'd1);
        check("grant_key_e8", 32'(key_out), 32'(KEY));
        release_req = 1'b1; step(); release_req = 1'b0;
        check("release_key", 32'(key_out), 32'h00);
        check("release_idle", 32'(dut.state_reg), 32'(ST_IDLE));

        // Silent lock: four timed-out attempts then DENIED.
        do_reset();
        pulse_start();
        repeat (15) step();
        check("to_present_last", 32'(key_out), 32'(KEY));
        step();
        check("to_gap_key", 32'(key_out), 32'h00);
        check("to_gap_busy", 32'(busy), 32'd1);
        check("to_retry1", 32'(retry_count), 32'd1);
        repeat (3) step();
        check("to_gap_last", 32'(key_out), 32'h00);
        step();
        check("to_present2", 32'(key_out), 32'(KEY));
        repeat (16) step();
        check("to_retry2", 32'(retry_count), 32'd2);
        repeat (20) step();
        check("to_retry3", 32'(retry_count), 32'd3);
        repeat (4) step();
        check("to_present4", 32'(key_out), 32'(KEY));
        repeat (15) step();
        check("to_denied_not_yet", 32'(denied), 32'd0);
        step();
        check("to_denied", 32'(denied), 32'd1);
        check("to_denied_key", 32'(key_out), 32'h00);
        check("to_denied_retry", 32'(retry_count), 32'd3);
        pulse_start();
        check("denied_restart_retry", 32'(retry_count), 32'd0);
        check("denied_restart_key", 32'(key_out), 32'(KEY));

        // Abort while in the gap between attempts.
        repeat (16) step();
        check("abort_pre_gap", 32'({busy, key_out}), 32'h100);
        abort = 1'b1; step(); abort = 1'b0;
        check("abort_key", 32'(key_out), 32'h00);
        check("abort_flags", 32'({busy, granted, denied, fault}), 32'h0);
        check("abort_retry", 32'(retry_count), 32'd0);

        // Enable dropped for 10 cycles mid-attempt.
        do_reset();
        pulse_start();
        repeat (5) step();
        ena = 1'b0;
        step();
        check("ena_low_key", 32'(key_out), 32'h00);
        repeat (9) step();
        ena = 1'b1;
        repeat (10) step();
        check("ena_resume_present", 32'(key_out), 32'(KEY));
        step();
        check("ena_resume_timeout", 32'(key_out), 32'h00);
        check("ena_resume_retry", 32'(retry_count), 32'd1);

        // One synchronized low cycle during HOLD, then a stable grant.
        do_reset();
        lock_mode = 1;
        pulse_start();
        repeat (3) step();
        glitch = 1'b1;
        step();
        check("glitch_hold_e4", 32'(dut.state_reg), 32'(ST_HOLD));
        repeat (3) step();
        check("glitch_present_e7", 32'(dut.state_reg), 32'(ST_PRESENT));
        check("glitch_model_e7", 32'(m_ph), 32'(M_PRESENT));
        step();
        check("glitch_rehold_e8", 32'(dut.state_reg), 32'(ST_HOLD));
        repeat (3) step();
        check("glitch_not_yet_e11", 32'(granted), 32'd0);
        step();
        check("glitch_grant_e12", 32'(granted), 32'd1);

        // Asynchronous reset while granted.
        rst_n = 1'b0;
        #1;
        check("rst_async_key", 32'(key_out), 32'h00);
        check("rst_async_granted", 32'(granted), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        check("rst_after_flags", 32'({busy, granted, denied, fault, retry_count}), 32'h0);

        // Corrupted state code traps into FAULT.
        chk_en = 1'b0;
        lock_mode = 0;
        force dut.state_reg = 8'h01;
        #1;
        release dut.state_reg;
        check("illegal_key", 32'(key_out), 32'h00);
        step();
        check("fault_set", 32'(fault), 32'd1);
        check("fault_key", 32'(key_out), 32'h00);
        start = 1'b1; abort = 1'b1; release_req = 1'b1;
        step();
        start = 1'b0; abort = 1'b0; release_req = 1'b0;
        step();
        check("fault_sticky", 32'({fault, busy, granted, denied}), 32'h8);
        check("fault_sticky_key", 32'(key_out), 32'h00);
        rst_n = 1'b0;
        #1;
        check("fault_cleared", 32'(fault), 32'd0);
        check("fault_idle", 32'(dut.state_reg), 32'(ST_IDLE));
        do_reset();
        chk_en = 1'b1;

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 49) == 0) lock_mode = int'($urandom_range(0, 2));
            ena         = ($urandom_range(0, 9) != 0);
            start       = ($urandom_range(0, 9) == 0);
            abort       = ($urandom_range(0, 79) == 0);
            release_req = ($urandom_range(0, 14) == 0);
            step();
        end
        start = 1'b0; abort = 1'b0; release_req = 1'b0;
        step();
        chk_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
